// File: rtl/line_fill_buffer_if.sv
// Cache-side, memory-side and line-delivery signals of the line fill buffer.
// slave is the buffer's view; master is the cache/memory environment's view.
interface line_fill_buffer_if #(
  parameter int DATA_SIZE      = 32,
  parameter int WORDS_PER_LINE = 8,
  parameter int ADDR_SIZE      = 32
);
  logic                                req_valid;
  logic                                req_ready;
  logic [ADDR_SIZE-1:0]                req_addr;
  logic                                mem_req_valid;
  logic                                mem_req_ready;
  logic [ADDR_SIZE-1:0]                mem_addr;
  logic                                mem_rsp_valid;
  logic [DATA_SIZE-1:0]                mem_rsp_data;
  logic                                line_valid;
  logic                                line_ready;
  logic [ADDR_SIZE-1:0]                line_addr;
  logic [WORDS_PER_LINE*DATA_SIZE-1:0] line_data;
  logic                                crit_valid;
  logic [DATA_SIZE-1:0]                crit_data;

  modport slave (
    input  req_valid, req_addr, mem_req_ready, mem_rsp_valid, mem_rsp_data, line_ready,
    output req_ready, mem_req_valid, mem_addr, line_valid, line_addr, line_data,
           crit_valid, crit_data
  );

  modport master (
    output req_valid, req_addr, mem_req_ready, mem_rsp_valid, mem_rsp_data, line_ready,
    input  req_ready, mem_req_valid, mem_addr, line_valid, line_addr, line_data,
           crit_valid, crit_data
  );
endinterface

// File: rtl/line_fill_buffer.sv
// Line fill buffer: fetches one cache line word by word and presents it whole.
// Define CRITICAL_WORD_FIRST_EN to start at the missing word and pulse crit_valid.
module lfb_slot #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (we) q <= d;
  end
endmodule

module line_fill_buffer #(
  parameter int DATA_SIZE      = 32,
  parameter int WORDS_PER_LINE = 8,
  parameter int ADDR_SIZE      = 32
) (
  input  logic               clk,
  input  logic               rst,
  line_fill_buffer_if.slave  bus
);
  localparam int OFFSET    = $clog2(DATA_SIZE/8);
  localparam int WORD_BITS = $clog2(WORDS_PER_LINE);
  localparam int LINE_LSB  = WORD_BITS + OFFSET;
  localparam int BASE_W    = ADDR_SIZE - LINE_LSB;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  // Packed as {base, idx} so it maps straight onto the word-address bits.
  typedef struct packed {
    logic [BASE_W-1:0]    base;
    logic [WORD_BITS-1:0] idx;
  } fill_t;

  state_t                                  state_q, state_d;
  fill_t                                   fill_q;
  logic [WORD_BITS:0]                      cnt_q;
  logic                                    req_ready;
  logic                                    accept;
  logic                                    fill_we;
  logic                                    last_word;
  logic [WORD_BITS-1:0]                    start_idx;
  logic [ADDR_SIZE-1:0]                    word_addr;
  logic [ADDR_SIZE-1:0]                    line_base;
  logic [WORDS_PER_LINE-1:0][DATA_SIZE-1:0] slot_q;
  logic                                    unused_addr;

  assign unused_addr = ^bus.req_addr[LINE_LSB-1:0];

`ifdef CRITICAL_WORD_FIRST_EN
  assign start_idx = bus.req_addr[LINE_LSB-1:OFFSET];
`else
  assign start_idx = '0;
`endif

  // Gated by rst so the cache never sees ready while reset is still held.
  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = bus.req_valid && req_ready;
  assign last_word = (cnt_q == (WORD_BITS+1)'(WORDS_PER_LINE-1));

  always_comb begin
    state_d = state_q;
    fill_we = 1'b0;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   if (bus.mem_req_ready) state_d = WAIT;
      WAIT: begin
        if (bus.mem_rsp_valid) begin
          fill_we = 1'b1;
          state_d = last_word ? DONE : ISSUE;
        end
      end
      DONE:    if (bus.line_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      fill_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        fill_q.base <= bus.req_addr[ADDR_SIZE-1:LINE_LSB];
        fill_q.idx  <= start_idx;
        cnt_q       <= '0;
      end else if (fill_we) begin
        fill_q.idx  <= fill_q.idx + WORD_BITS'(1);
        cnt_q       <= cnt_q + (WORD_BITS+1)'(1);
      end
    end
  end

  for (genvar i = 0; i < WORDS_PER_LINE; i++) begin : g_slot
    lfb_slot #(.W(DATA_SIZE)) u_slot (
      .clk (clk),
      .rst (rst),
      .we  (fill_we && (fill_q.idx == WORD_BITS'(i))),
      .d   (bus.mem_rsp_data),
      .q   (slot_q[i])
    );
  end

  always_comb begin
    word_addr                        = '0;
    word_addr[ADDR_SIZE-1:OFFSET]    = fill_q;
    line_base                        = '0;
    line_base[ADDR_SIZE-1:LINE_LSB]  = fill_q.base;
  end

  assign bus.req_ready     = req_ready;
  assign bus.mem_req_valid = (state_q == ISSUE);
  assign bus.mem_addr      = (state_q == ISSUE) ? word_addr : '0;
  assign bus.line_valid    = (state_q == DONE);
  assign bus.line_addr     = (state_q == DONE) ? line_base : '0;
  assign bus.line_data     = slot_q;

`ifdef CRITICAL_WORD_FIRST_EN
  logic                 crit_valid_q;
  logic [DATA_SIZE-1:0] crit_data_q;
  logic                 crit_hit;

  // The first response of a fill is always the requested word.
  assign crit_hit = fill_we && (cnt_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crit_valid_q <= 1'b0;
      crit_data_q  <= '0;
    end else begin
      crit_valid_q <= crit_hit;
      crit_data_q  <= crit_hit ? bus.mem_rsp_data : '0;
    end
  end

  assign bus.crit_valid = crit_valid_q;
  assign bus.crit_data  = crit_data_q;
`else
  assign bus.crit_valid = 1'b0;
  assign bus.crit_data  = '0;
`endif
endmodule

// File: tb/tb_line_fill_buffer.sv
// Directed bench for line_fill_buffer: default instance with a memory responder,
// plus a 2x64-bit instance driven cycle by cycle.
module tb_line_fill_buffer;
  logic clk;
  logic rst;

  line_fill_buffer_if #(.DATA_SIZE(32), .WORDS_PER_LINE(8), .ADDR_SIZE(32)) bus ();
  line_fill_buffer_if #(.DATA_SIZE(64), .WORDS_PER_LINE(2), .ADDR_SIZE(32)) bus2 ();

  line_fill_buffer #(.DATA_SIZE(32), .WORDS_PER_LINE(8), .ADDR_SIZE(32)) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );
  line_fill_buffer #(.DATA_SIZE(64), .WORDS_PER_LINE(2), .ADDR_SIZE(32)) dut2 (
    .clk (clk), .rst (rst), .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // memory responder controls and logs
  int          stall_cycles = 0;
  bit          spur_en      = 0;
  logic [31:0] addr_log[$];
  int          stall_cnt    = 0;
  bit          stalling     = 0;
  logic [31:0] held_addr    = '0;
  int          stall_bad    = 0;
  int          stalls_seen  = 0;
  int          spur_cnt     = 0;
  int          rsp_cnt      = 0;
  bit          pend         = 0;
  logic [31:0] pend_data    = '0;
  int          crit_cnt     = 0;
  logic [31:0] crit_last    = '0;
  int          lv_cnt       = 0;

  // Memory returns the requested address as data, one cycle after handshake.
  always @(negedge clk) begin
    if (rst) begin
      pend = 0; stall_cnt = 0; stalling = 0;
      bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0;
    end else begin
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_data  = '0;
      if (pend) begin
        bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = pend_data; pend = 0; rsp_cnt++;
      end else if (spur_en && (bus.mem_req_valid || bus.req_ready)) begin
        bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'hDEAD_BEEF; spur_cnt++;
      end
      if (stalling && (!bus.mem_req_valid || bus.mem_addr !== held_addr)) stall_bad++;
      stalling = 0;
      if (bus.mem_req_valid) begin
        if (stall_cnt < stall_cycles) begin
          bus.mem_req_ready = 1'b0; stall_cnt++; stalls_seen++;
          held_addr = bus.mem_addr; stalling = 1;
        end else begin
          bus.mem_req_ready = 1'b1; stall_cnt = 0;
          pend = 1; pend_data = bus.mem_addr; addr_log.push_back(bus.mem_addr);
        end
      end else begin
        bus.mem_req_ready = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.crit_valid) begin crit_cnt++; crit_last = bus.crit_data; end
    if (bus.line_valid) lv_cnt++;
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] line_of(input logic [31:0] base);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = base + 32'(4*i);
    return r;
  endfunction

  function automatic logic [31:0] exp_addr(input logic [31:0] req, input int k);
    int s;
`ifdef CRITICAL_WORD_FIRST_EN
    s = int'(req[4:2]);
`else
    s = 0;
`endif
    return {req[31:5], 5'b0} + 32'(4*((s+k)%8));
  endfunction

  // Call at a negedge; returns at the negedge where line_valid is first seen.
  task automatic run_fill(input logic [31:0] addr, input bit busy_req, output int cyc, output bit saw_ready);
    bus.req_valid = 1'b1; bus.req_addr = addr; cyc = 0; saw_ready = 0;
    while (cyc < 400) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (busy_req) begin
        bus.req_valid = 1'b1; bus.req_addr = 32'h5000;
        if (bus.req_ready) saw_ready = 1;
      end else begin
        bus.req_valid = 1'b0;
      end
      if (bus.line_valid) break;
    end
    bus.req_valid = 1'b0;
    check("fill_timeout", bus.line_valid, 1'b1);
  endtask

  task automatic check_addrs(input string tag, input int a0, input logic [31:0] req);
    check({tag, "_n"}, addr_log.size() - a0, 8);
    for (int k = 0; k < 8; k++)
      check($sformatf("%s_addr%0d", tag, k), addr_log[a0+k], exp_addr(req, k));
  endtask

  task automatic consume_line();
    bus.line_ready = 1'b1;
    @(negedge clk);
    bus.line_ready = 1'b0;
  endtask

  initial begin
    int cyc, a0, c0, l0, s0, r0, n, hits;
    bit saw;
    logic [255:0] snap;
    logic [31:0]  e2 [2];

    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.line_ready = 1'b0;
    bus2.req_valid = 1'b0; bus2.req_addr = '0; bus2.line_ready = 1'b0;
    bus2.mem_req_ready = 1'b0; bus2.mem_rsp_valid = 1'b0; bus2.mem_rsp_data = '0;
    repeat (2) @(negedge clk);

    check("rst_req_ready",  bus.req_ready, 1'b0);
    check("rst_mem_valid",  bus.mem_req_valid, 1'b0);
    check("rst_mem_addr",   bus.mem_addr, 32'h0);
    check("rst_line_valid", bus.line_valid, 1'b0);
    check("rst_line_addr",  bus.line_addr, 32'h0);
    check("rst_line_data",  bus.line_data, 256'h0);
    check("rst_crit_valid", bus.crit_valid, 1'b0);
    rst = 1'b0;
    #1;
    check("rel_req_ready", bus.req_ready, 1'b1);
    @(negedge clk);

    // Fill with immediate memory, request 0x1014
    a0 = addr_log.size(); c0 = crit_cnt;
    run_fill(32'h1014, 0, cyc, saw);
    check("a_latency",   cyc, 17);
    check("a_line_addr", bus.line_addr, 32'h1000);
    check("a_line_data", bus.line_data, line_of(32'h1000));
    check_addrs("a", a0, 32'h1014);
`ifdef CRITICAL_WORD_FIRST_EN
    check("a_crit_cnt",  crit_cnt - c0, 1);
    check("a_crit_data", crit_last, 32'h1014);
`else
    check("a_crit_cnt",  crit_cnt - c0, 0);
`endif
    consume_line();
    check("a_idle_ready", bus.req_ready, 1'b1);
    check("a_lv_low",     bus.line_valid, 1'b0);
    check("a_retain",     bus.line_data, line_of(32'h1000));

    // Stalled memory, stalled consumer, competing request during fill
    stall_cycles = 5; a0 = addr_log.size(); s0 = stalls_seen;
    run_fill(32'h3008, 1, cyc, saw);
    check("b_latency",   cyc, 57);
    check("b_busy_rdy",  saw, 1'b0);
    check("b_stall_bad", stall_bad, 0);
    check("b_stalls",    stalls_seen - s0, 40);
    check_addrs("b", a0, 32'h3008);
    snap = bus.line_data;
    check("b_line_data", snap, line_of(32'h3000));
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      check("b_hold_valid", bus.line_valid, 1'b1);
      check("b_hold_addr",  bus.line_addr, 32'h3000);
      check("b_hold_data",  bus.line_data, snap);
      check("b_hold_rdy",   bus.req_ready, 1'b0);
    end
    consume_line();
    check("b_idle_ready", bus.req_ready, 1'b1);
    check("b_no_new_req", bus.mem_req_valid, 1'b0);

    // Spurious responses in IDLE and ISSUE
    stall_cycles = 1; spur_en = 1; s0 = spur_cnt;
    @(negedge clk);
    run_fill(32'h1014, 0, cyc, saw);
    spur_en = 0;
    check("c_latency", cyc, 25);
    check("c_spur_seen", spur_cnt - s0 > 8, 1'b1);
    hits = 0;
    for (int i = 0; i < 8; i++) if (bus.line_data[i*32 +: 32] == 32'hDEAD_BEEF) hits++;
    check("c_beef_slots", hits, 0);
    check("c_line_data", bus.line_data, line_of(32'h1000));
    consume_line();

    // Reset after the third response, then a fresh fill
    stall_cycles = 0; l0 = lv_cnt; r0 = rsp_cnt; n = 0;
    bus.req_valid = 1'b1; bus.req_addr = 32'h1014;
    @(posedge clk); @(negedge clk);
    bus.req_valid = 1'b0;
    while ((rsp_cnt - r0) < 3 && n < 50) begin @(negedge clk); n++; end
    check("d_rsp_timeout", (rsp_cnt - r0) >= 3, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("d_rst_lv",    bus.line_valid, 1'b0);
    check("d_rst_rdy",   bus.req_ready, 1'b0);
    check("d_rst_mem",   bus.mem_req_valid, 1'b0);
    check("d_rst_data",  bus.line_data, 256'h0);
    check("d_rst_crit",  bus.crit_valid, 1'b0);
    c0 = crit_cnt;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("d_no_lv",   lv_cnt - l0, 0);
    check("d_no_crit", crit_cnt - c0, 0);
    run_fill(32'h2000, 0, cyc, saw);
    check("d_latency",   cyc, 17);
    check("d_line_addr", bus.line_addr, 32'h2000);
    check("d_line_data", bus.line_data, line_of(32'h2000));
`ifdef CRITICAL_WORD_FIRST_EN
    check("d_crit_cnt",  crit_cnt - c0, 1);
    check("d_crit_data", crit_last, 32'h2000);
`else
    check("d_crit_cnt",  crit_cnt - c0, 0);
`endif
    consume_line();

    // Two-word line of 64-bit words, request 0x48
`ifdef CRITICAL_WORD_FIRST_EN
    e2[0] = 32'h48; e2[1] = 32'h40;
`else
    e2[0] = 32'h40; e2[1] = 32'h48;
`endif
    check("e_req_ready", bus2.req_ready, 1'b1);
    bus2.req_valid = 1'b1; bus2.req_addr = 32'h48;
    @(posedge clk); @(negedge clk);
    bus2.req_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("e_mem_valid%0d", k), bus2.mem_req_valid, 1'b1);
      check($sformatf("e_mem_addr%0d", k),  bus2.mem_addr, e2[k]);
      bus2.mem_req_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      bus2.mem_req_ready = 1'b0;
      bus2.mem_rsp_valid = 1'b1; bus2.mem_rsp_data = 64'(e2[k]);
      @(posedge clk); @(negedge clk);
      bus2.mem_rsp_valid = 1'b0; bus2.mem_rsp_data = '0;
      if (k == 0) begin
`ifdef CRITICAL_WORD_FIRST_EN
        check("e_crit_valid", bus2.crit_valid, 1'b1);
        check("e_crit_data",  bus2.crit_data, 64'h48);
`else
        check("e_crit_valid", bus2.crit_valid, 1'b0);
`endif
      end
    end
    check("e_line_valid", bus2.line_valid, 1'b1);
    check("e_line_addr",  bus2.line_addr, 32'h40);
    check("e_line_data",  bus2.line_data, {64'h48, 64'h40});
    bus2.line_ready = 1'b1;
    @(negedge clk);
    bus2.line_ready = 1'b0;
    check("e_idle_ready", bus2.req_ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
